// File: rtl/block_allocator_pkg.sv
// Shared types and helpers for the block allocator: op codes, FSM states,
// header flag position and block-index wrap. Optional feature macro: ALLOC_COUNT_EN.
package mem_alloc_pkg;

  typedef enum logic [1:0] {
    OP_ALLOC = 2'd0,
    OP_FREE  = 2'd1,
    OP_SET   = 2'd2,
    OP_QUERY = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic int flag_bit(input int data_w);
    return data_w - 1;
  endfunction

  // Block 0 is reserved, so the last block wraps back to block 1.
  function automatic int unsigned blk_succ(input int unsigned idx, input int unsigned nblk);
    return (idx >= nblk - 32'd1) ? 32'd1 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/block_allocator_if.sv
// Request/response bundle between the RAM controller op mux and the block allocator.
// Optional feature macro ALLOC_COUNT_EN does not change this bundle.
interface block_allocator_if #(
  parameter int ADDR_W = 10
);
  logic                start;
  mem_alloc_pkg::op_e  op;
  logic [ADDR_W-1:0]   arg_addr;
  logic                busy;
  logic                done;
  logic                ok;
  logic                full;
  logic [ADDR_W-1:0]   result_addr;

  modport master (
    output start, op, arg_addr,
    input  busy, done, ok, full, result_addr
  );

  modport slave (
    input  start, op, arg_addr,
    output busy, done, ok, full, result_addr
  );
endinterface

// File: rtl/block_allocator_ptr_wrap.sv
// Block-index register with wrapped increment (last block -> 1); used for both
// the next-fit pointer and the scan pointer. Optional feature macro: ALLOC_COUNT_EN (unused here).
module block_ptr_wrap
  import mem_alloc_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int NBLK  = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             step,
  output logic [IDX_W-1:0] ptr
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (step) begin
      ptr_d = IDX_W'(blk_succ(32'(ptr_q), NBLK));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= IDX_W'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/block_allocator.sv
// Next-fit block allocator over a single-port synchronous RAM (alloc/free/set/query).
// Optional feature macro ALLOC_COUNT_EN adds used_count and a fast full path for ALLOC.
//
// state   | meaning
// S_IDLE  | waiting for start; argument check and address load on accept
// S_WAIT  | counting RAM read latency for the header at ram_address
// S_CHECK | header flag valid on ram_q; decide write, skip, or finish
// S_WRITE | one-cycle header write
// S_DONE  | done pulse; ok/full/result_addr valid
module block_allocator
  import mem_alloc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 32,
  parameter int RD_LAT      = 1
) (
  input  logic               clock,
  input  logic               resetn,
  block_allocator_if.slave   bus,
  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_clock,
  output logic [DATA_W-1:0]  ram_data,
  output logic               ram_wren,
  input  logic [DATA_W-1:0]  ram_q
`ifdef ALLOC_COUNT_EN
  ,
  output logic [ADDR_W-1:0]  used_count
`endif
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int NBLK  = 1 << IDX_W;
  localparam int FLAG  = flag_bit(DATA_W);
  localparam logic [DATA_W-1:0] FLAG_WORD = DATA_W'(1) << FLAG;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] res_q, res_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic              ok_q, ok_d;
  logic              full_q, full_d;

  logic [IDX_W-1:0]  next_ptr, scan_ptr, scan_succ;
  logic              scan_load, scan_step, next_load;
  logic              flag, arg_bad, cnt_full;
  logic              unused_q_bits;

  assign flag          = ram_q[FLAG];
  assign unused_q_bits = ^ram_q[FLAG-1:0];
  assign arg_bad       = (bus.arg_addr == '0) || (bus.arg_addr[OFF_W-1:0] != '0);
  assign scan_succ     = IDX_W'(blk_succ(32'(scan_ptr), NBLK));

  block_ptr_wrap #(.IDX_W(IDX_W), .NBLK(NBLK)) u_next_ptr (
    .clock    (clock),
    .resetn   (resetn),
    .load     (next_load),
    .load_val (scan_succ),
    .step     (1'b0),
    .ptr      (next_ptr)
  );

  block_ptr_wrap #(.IDX_W(IDX_W), .NBLK(NBLK)) u_scan_ptr (
    .clock    (clock),
    .resetn   (resetn),
    .load     (scan_load),
    .load_val (next_ptr),
    .step     (scan_step),
    .ptr      (scan_ptr)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    ok_d      = ok_q;
    full_d    = full_q;
    scan_load = 1'b0;
    scan_step = 1'b0;
    next_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          cnt_d  = '0;
          wait_d = 2'(RD_LAT - 1);
          ok_d   = 1'b0;
          full_d = 1'b0;
          res_d  = bus.arg_addr;
          if (bus.op == OP_ALLOC) begin
            res_d = '0;
            if (cnt_full) begin
              full_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              scan_load = 1'b1;
              addr_d    = {next_ptr, {OFF_W{1'b0}}};
              state_d   = S_WAIT;
            end
          end else if (arg_bad) begin
            state_d = S_DONE;
          end else begin
            addr_d  = bus.arg_addr;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_CHECK: begin
        res_d = addr_q;
        unique case (op_q)
          OP_ALLOC: begin
            if (!flag) begin
              state_d = S_WRITE;
            end else begin
              scan_step = 1'b1;
              addr_d    = {scan_succ, {OFF_W{1'b0}}};
              cnt_d     = cnt_q + IDX_W'(1);
              wait_d    = 2'(RD_LAT - 1);
              if (cnt_d == IDX_W'(NBLK - 1)) begin
                full_d  = 1'b1;
                res_d   = '0;
                state_d = S_DONE;
              end else begin
                state_d = S_WAIT;
              end
            end
          end
          OP_FREE: state_d = flag ? S_WRITE : S_DONE;
          OP_SET:  state_d = flag ? S_DONE : S_WRITE;
          default: begin
            ok_d    = flag;
            state_d = S_DONE;
          end
        endcase
      end
      S_WRITE: begin
        ok_d      = 1'b1;
        next_load = (op_q == OP_ALLOC);
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= OP_ALLOC;
      addr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      ok_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      ok_q    <= ok_d;
      full_q  <= full_d;
    end
  end

`ifdef ALLOC_COUNT_EN
  logic [ADDR_W-1:0] used_q, used_d;

  always_comb begin
    used_d = used_q;
    if (ram_wren) begin
      used_d = (op_q == OP_FREE) ? used_q - ADDR_W'(1) : used_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      used_q <= '0;
    end else begin
      used_q <= used_d;
    end
  end

  assign used_count = used_q;
  assign cnt_full   = (used_q == ADDR_W'(NBLK - 1));
`else
  assign cnt_full = 1'b0;
`endif

  assign ram_clock       = clock;
  assign ram_address     = addr_q;
  assign ram_wren        = (state_q == S_WRITE);
  assign ram_data        = (ram_wren && op_q != OP_FREE) ? FLAG_WORD : '0;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.ok          = ok_q;
  assign bus.full        = full_q;
  assign bus.result_addr = res_q;

endmodule

// File: tb/tb_block_allocator.sv
// Scoreboard bench for block_allocator: a block-level model predicts each
// completion, and a monitor compares it when done pulses.
module tb_block_allocator;
  import mem_alloc_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BW     = 32;
  localparam int RD_LAT = 1;
  localparam int NBLK   = (1 << ADDR_W) / BW;

  typedef struct {
    logic              ok;
    logic              full;
    logic [ADDR_W-1:0] res;
    int                lat;
    int                t0;
    int                wr;
    logic              chk;
    logic              flag;
  } exp_t;

  logic clock, resetn, mem_clr;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_clock, ram_wren;
  logic [DATA_W-1:0] ram_data, ram_q;
`ifdef ALLOC_COUNT_EN
  logic [ADDR_W-1:0] used_count;
`endif

  block_allocator_if #(.ADDR_W(ADDR_W)) bus ();

  block_allocator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .RD_LAT(RD_LAT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_clock   (ram_clock),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
`ifdef ALLOC_COUNT_EN
    ,
    .used_count  (used_count)
`endif
  );

  // RAM with RD_LAT-cycle read path
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge ram_clock) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    rd_pipe[0] <= mem[ram_address];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_q = rd_pipe[RD_LAT-1];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  initial forever @(posedge clock) cyc++;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   wr_seen = 0;

  // Reference model: allocation flag per block, next-fit pointer, write count
  bit flags [NBLK];
  int nptr;
  int used;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        wr_seen = 0;
      end else begin
        if (ram_wren) wr_seen++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            check("ok", 32'(bus.ok), 32'(e.ok));
            check("full", 32'(bus.full), 32'(e.full));
            check("result_addr", 32'(bus.result_addr), 32'(e.res));
            check("latency", 32'(cyc - e.t0), 32'(e.lat));
            check("write_count", 32'(wr_seen), 32'(e.wr));
            if (e.chk) check("header_flag", 32'(mem[e.res][DATA_W-1]), 32'(e.flag));
          end
          wr_seen = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clock);
      bus.start = 1'b0;
      if (exp_q.size() == 0 && !bus.busy) break;
      n++;
      if (n > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: got no done in 400 cycles expected done");
        exp_q.delete();
        break;
      end
      if (bus.busy && $urandom_range(0, 3) == 0) begin
        bus.start    = 1'b1;
        bus.op       = op_e'($urandom_range(0, 3));
        bus.arg_addr = ADDR_W'($urandom);
      end
    end
  endtask

  task automatic issue(input op_e o, input int a);
    exp_t e;
    int   b, k;
    bit   found;
    wait_idle();
    e = '{ok:1'b0, full:1'b0, res:ADDR_W'(a), lat:1, t0:cyc, wr:0, chk:1'b0, flag:1'b0};
    if (o == OP_ALLOC) begin
      e.res = '0;
`ifdef ALLOC_COUNT_EN
      found = (used == NBLK - 1);
`else
      found = 1'b0;
`endif
      if (found) begin
        e.full = 1'b1;
      end else begin
        b = nptr;
        k = 0;
        while (k < NBLK - 1 && flags[b]) begin
          k++;
          b = (b == NBLK - 1) ? 1 : b + 1;
        end
        if (k < NBLK - 1) begin
          flags[b] = 1'b1;
          nptr     = (b == NBLK - 1) ? 1 : b + 1;
          used++;
          e = '{ok:1'b1, full:1'b0, res:ADDR_W'(b * BW), lat:3 + RD_LAT + k * (1 + RD_LAT),
                t0:cyc, wr:1, chk:1'b1, flag:1'b1};
        end else begin
          e.full = 1'b1;
          e.lat  = 2 + RD_LAT + (NBLK - 2) * (1 + RD_LAT);
        end
      end
    end else if (a != 0 && a % BW == 0) begin
      b     = a / BW;
      e.lat = 2 + RD_LAT;
      if (o == OP_QUERY) begin
        e.ok = flags[b];
      end else if ((o == OP_FREE) == flags[b]) begin
        flags[b] = (o == OP_SET);
        used     = (o == OP_SET) ? used + 1 : used - 1;
        e.ok  = 1'b1;
        e.lat = 3 + RD_LAT;
        e.wr  = 1;
        e.chk = 1'b1;
        e.flag = (o == OP_SET);
      end
    end
    exp_q.push_back(e);
    bus.start    = 1'b1;
    bus.op       = o;
    bus.arg_addr = ADDR_W'(a);
    @(negedge clock);
    bus.start    = 1'b0;
    bus.op       = op_e'($urandom_range(0, 3));
    bus.arg_addr = ADDR_W'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ok", 32'(bus.ok), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_result_addr", 32'(bus.result_addr), 0);
    check("rst_ram_address", 32'(ram_address), 0);
    check("rst_ram_wren", 32'(ram_wren), 0);
    exp_q.delete();
    nptr = 1;
    used = 0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    resetn       = 1'b0;
    mem_clr      = 1'b1;
    bus.start    = 1'b0;
    bus.op       = OP_ALLOC;
    bus.arg_addr = '0;
    nptr         = 1;
    used         = 0;
    for (int i = 0; i < NBLK; i++) flags[i] = 1'b0;
    repeat (3) @(negedge clock);
    mem_clr = 1'b0;
    resetn  = 1'b1;
    @(negedge clock);
    check("init_busy", 32'(bus.busy), 0);
    check("init_done", 32'(bus.done), 0);
    check("init_ok", 32'(bus.ok), 0);
    check("init_full", 32'(bus.full), 0);
    check("init_result_addr", 32'(bus.result_addr), 0);
    check("init_ram_address", 32'(ram_address), 0);
    check("init_ram_wren", 32'(ram_wren), 0);
    check("init_ram_data", ram_data, 0);

    issue(OP_ALLOC, 0);
    issue(OP_ALLOC, 0);
    issue(OP_SET, 96);
    issue(OP_SET, 128);
    issue(OP_SET, 160);
    wait_idle();
    do_reset();
    issue(OP_ALLOC, 0);
    issue(OP_FREE, 64);
    issue(OP_FREE, 64);
    issue(OP_FREE, 0);
    issue(OP_FREE, 33);
    issue(OP_QUERY, 32);
    issue(OP_QUERY, 64);
    for (int b = 1; b < NBLK; b++) if (!flags[b]) issue(OP_SET, b * BW);
    issue(OP_ALLOC, 0);
    issue(OP_FREE, (NBLK - 1) * BW);
    wait_idle();
    do_reset();

    // Long scan aborted by reset; a stray start arrives while busy
    issue(OP_ALLOC, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bus.start = (i == 5);
      if (i == 5) begin
        bus.op       = OP_FREE;
        bus.arg_addr = ADDR_W'(64);
      end
    end
    do_reset();
    flags[NBLK-1] = 1'b0;
    check("abort_no_write", 32'(mem[(NBLK-1)*BW][DATA_W-1]), 0);
    issue(OP_ALLOC, 0);

    for (int i = 0; i < 80; i++) begin
      int o, a;
      o = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, (1 << ADDR_W) - 1);
      else a = $urandom_range(0, NBLK - 1) * BW;
      issue(op_e'(o), a);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_allocator.md
# block_allocator

Parametrised block allocator over a single-port synchronous RAM. It is the next generation of the card-list memory allocator. It manages fixed-size blocks whose header word carries an "allocated" flag, and it supports four operations: next-fit allocate, free, set, and query. It adds reset, wrap-around scanning, full detection, double-free detection and configurable RAM read latency. It sits between the RAM controller's operation mux and the RAM instance, in place of the allocate and set modules.

## Interface
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, RAM word width
- BLOCK_WORDS, 32, words per block; power of two; header is word 0 of each block
- RD_LAT, 1, cycles from a ram_address value to the matching ram_q value (1 or 2)
- clock  in  1  sole clock; ram_clock is a straight copy of it
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  0 ALLOC, 1 FREE, 2 SET, 3 QUERY
- arg_addr  in  ADDR_W  block header address for FREE/SET/QUERY; ignored by ALLOC
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- ok  out  1  valid with done; operation succeeded (for QUERY: the block is allocated)
- full  out  1  valid with done; ALLOC found no free block
- result_addr  out  ADDR_W  valid with done; header address operated on or allocated
- ram_address  out  ADDR_W; ram_clock  out  1; ram_data  out  DATA_W; ram_wren  out  1
- ram_q  in  DATA_W  RAM read data

## Operation
- NBLK = 2^ADDR_W / BLOCK_WORDS. Block 0 (address 0) is reserved and never allocated. The usable blocks are 1..NBLK-1.
- The flag is bit DATA_W-1 of the header. Writes drive ram_data with the flag set (ALLOC/SET) or clear (FREE) and all other bits 0.
- The scan pointer next_ptr holds a block index. It resets to 1. After a successful ALLOC of block b it moves to b+1, wrapping from NBLK-1 to 1. No other operation moves it.
- Argument check in IDLE for FREE, SET and QUERY:
  - If arg_addr is 0 or not a multiple of BLOCK_WORDS, go straight to DONE with ok=0 and no RAM access.
- States:
  - IDLE: on start, load ram_address (next_ptr×BLOCK_WORDS for ALLOC, arg_addr otherwise), clear the scan count, go to WAIT.
  - WAIT: count RD_LAT cycles, then go to CHECK.
  - CHECK, ALLOC: flag 0 → WRITE. Otherwise advance ram_address with wrap and increment the scan count. If the scan count reaches NBLK-1 → DONE with full=1, ok=0. Else → WAIT.
  - CHECK, FREE: flag 1 → WRITE. Flag 0 (double free) → DONE with ok=0.
  - CHECK, SET: flag 0 → WRITE. Flag 1 → DONE with ok=0.
  - CHECK, QUERY: → DONE with ok equal to the flag.
  - WRITE: ram_wren=1 for exactly one cycle, then → DONE with ok=1.
  - DONE: done=1 for one cycle; full, ok and result_addr are valid; → IDLE.
- A start received while busy is ignored. Op and arg_addr are captured at acceptance; later changes have no effect.
- RAM contents are not initialised by this block; software or a prior SET/FREE pass prepares them.

## Timing
- Reset values: busy, done, ok, full and ram_wren are 0. ram_address, ram_data and result_addr are 0. State is IDLE.
- Reset mid-operation returns to IDLE at once. A RAM write occurs only if the block was already in the WRITE cycle.
- Latency is measured from the edge where start is sampled (T) to the cycle where done is high:
  - Invalid argument: T+1.
  - QUERY, or a rejected FREE/SET: T+2+RD_LAT.
  - FREE or SET with a write: T+3+RD_LAT.
  - ALLOC after skipping k occupied blocks: T+3+RD_LAT+k(1+RD_LAT).
  - ALLOC when full: T+2+RD_LAT+(NBLK-2)(1+RD_LAT). With default parameters this is T+63.
- The next start is accepted in the cycle after done.

## Configuration
- ALLOC_COUNT_EN defined:
  - Adds output used_count, ADDR_W bits, reset value 0.
  - used_count increments on each ALLOC/SET write and decrements on each FREE write.
  - When used_count equals NBLK-1, ALLOC completes at T+1 with full=1 and no scan.
- ALLOC_COUNT_EN undefined: there is no used_count port, and full is detected only by the full scan.

## Structure
- Package mem_alloc_pkg holds:
  - op codes OP_ALLOC, OP_FREE, OP_SET, OP_QUERY;
  - the state enum;
  - the flag-bit index helper.
- Sub-module block_ptr_wrap holds the block-index register with increment and wrap (NBLK-1 → 1). It is used for both next_ptr and the scan address.

## Test plan
- Reset, then ALLOC on zeroed RAM → done at T+4, ok=1, result_addr=32, header 32 flag set; a second ALLOC → result_addr=64.
- Blocks 1..5 allocated and next_ptr=1 → ALLOC returns result_addr=192 with done at T+14.
- FREE 64, then FREE 64 again → first call gives ok=1 with the flag cleared; second call gives ok=0 and no ram_wren pulse.
- FREE with arg_addr=0, then with arg_addr=33 → done at T+1, ok=0, no RAM access.
- All 31 blocks allocated → ALLOC gives full=1, ok=0 at T+63. With ALLOC_COUNT_EN defined, the same case completes at T+1.
- Reset asserted during the ALLOC scan → outputs return to 0 immediately, no write occurs, and a fresh ALLOC then completes normally; start pulsed while busy is ignored.
